// File: rtl/write_xfer_ctl.sv
// Write transfer controller: locks onto the arbiter-granted port and moves its packet
// word by word into a registered valid/ready SRAM write stage, truncating at MAX_WORDS.
module write_xfer_ctl #(
  parameter int NUM_PORTS = 16,
  parameter int SEL_W     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [SEL_W-1:0]            select,
  input  logic [NUM_PORTS*DATA_W-1:0] port_data,
  input  logic [NUM_PORTS-1:0]        port_valid,
  input  logic [NUM_PORTS-1:0]        port_eop,
  output logic [NUM_PORTS-1:0]        port_ready,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        wr_sop,
  output logic                        wr_eop,
  output logic [SEL_W-1:0]            wr_port,
  output logic                        grant_ack,
  output logic                        busy,
  output logic                        err_trunc
);

  // state | meaning
  // IDLE  | waiting for req[select]
  // GRANT | one cycle, acknowledge grant to arbiter
  // XFER  | moving words into the output register
  // FLUSH | packet truncated, discarding remaining words
  // DONE  | waiting for the last word to drain
  typedef enum logic [2:0] {IDLE, GRANT, XFER, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     cur_port;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    cur_data;
  logic                 cur_valid, cur_eop, sel_req;
  logic [NUM_PORTS-1:0] cur_onehot;
  logic                 load_ok, accept, at_limit;

  // Out-of-range select never matches a port, so it reads as req=0.
  always_comb begin
    cur_data   = '0;
    cur_valid  = 1'b0;
    cur_eop    = 1'b0;
    cur_onehot = '0;
    sel_req    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cur_port == SEL_W'(i)) begin
        cur_data      = port_data[i*DATA_W +: DATA_W];
        cur_valid     = port_valid[i];
        cur_eop       = port_eop[i];
        cur_onehot[i] = 1'b1;
      end
      if (select == SEL_W'(i)) sel_req = req[i];
    end
  end

  assign load_ok   = !wr_valid || wr_ready;
  assign at_limit  = (cnt == CNT_LAST);
  assign grant_ack = (state == GRANT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    port_ready = '0;
    accept     = 1'b0;
    case (state)
      IDLE:  if (sel_req) state_nxt = GRANT;
      GRANT: state_nxt = XFER;
      XFER: begin
        port_ready = load_ok ? cur_onehot : '0;
        accept     = cur_valid && load_ok;
        if (accept) begin
          if (cur_eop)       state_nxt = DONE;
          else if (at_limit) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        port_ready = cur_onehot;
        if (cur_valid && cur_eop) state_nxt = DONE;
      end
      DONE:    if (load_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_port  <= '0;
      cnt       <= '0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
      wr_sop    <= 1'b0;
      wr_eop    <= 1'b0;
      wr_port   <= '0;
      err_trunc <= 1'b0;
    end else begin
      err_trunc <= 1'b0;
      if (state == IDLE && sel_req) cur_port <= select;
      if (state == GRANT) begin
        cnt     <= '0;
        wr_port <= cur_port;
      end
      if (accept) begin
        wr_valid  <= 1'b1;
        wr_data   <= cur_data;
        wr_sop    <= (cnt == '0);
        wr_eop    <= cur_eop || at_limit;
        err_trunc <= !cur_eop && at_limit;
        cnt       <= cnt + 1'b1;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
        wr_sop   <= 1'b0;
        wr_eop   <= 1'b0;
      end
    end
  end

endmodule
